// File: rtl/frame_mem_arbiter_pkg.sv
// Shared types and defaults for the frame RAM arbiter.
// Holds the state encoding (last RAM operation) and default geometry.
package frame_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF     = 17;
  localparam int DATA_W_DEF     = 8;
  localparam int STARVE_MAX_DEF = 16;

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between display reader, scanner writer, frame RAM and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath.
interface frame_mem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              hblank;
  logic              vblank;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_done;
  logic              forced;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  hblank, vblank,
    input  rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data,
    input  wr_req, wr_addr, wr_data,
    output wr_ready, wr_done, forced,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output hblank, vblank,
    output rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data,
    output wr_req, wr_addr, wr_data,
    input  wr_ready, wr_done, forced,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/frame_mem_arbiter_wr_slot.sv
// Single-entry write holding register with starvation counter.
// wait_cnt counts cycles the entry sits unissued and saturates at STARVE_MAX.
module arb_wr_slot #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue,
  output logic              wr_ready,
  output logic              full,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data,
  output logic              starve
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] wait_cnt;

  // An entry cannot be refilled in the cycle it issues, capping writes at one per two cycles.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      full      <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
      wait_cnt  <= '0;
    end else begin
      if (issue) begin
        full <= 1'b0;
      end else if (wr_req && !full) begin
        full      <= 1'b1;
        slot_addr <= wr_addr;
        slot_data <= wr_data;
      end

      if (issue) begin
        wait_cnt <= '0;
      end else if (full && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign wr_ready = !full;
  assign starve   = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/frame_mem_arbiter.sv
// Arbitrates the single-port frame RAM between display reads and scanner writes.
// Display wins in active video, scanner in blanking; starvation forces a write.
module frame_mem_arbiter
  import frame_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic                clk,
  input logic                clr_n,
  frame_mem_arbiter_if.slave bus
);

  arb_state_t        state;
  logic              active;
  logic              full;
  logic              starve;
  logic              want_wr;
  logic              issue_wr;
  logic              to_turn;
  logic              grant_rd;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_valid_q;

  arb_wr_slot #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_slot (
    .clk      (clk),
    .clr_n    (clr_n),
    .wr_req   (bus.wr_req),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .issue    (issue_wr),
    .wr_ready (bus.wr_ready),
    .full     (full),
    .slot_addr(slot_addr),
    .slot_data(slot_data),
    .starve   (starve)
  );

  // Select is combinational so blanking edges act in the same cycle.
  always_comb begin
    active   = !bus.hblank && !bus.vblank;
    want_wr  = full && (starve || !active || !bus.rd_req);
    issue_wr = 1'b0;
    to_turn  = 1'b0;
    grant_rd = 1'b0;
    if (state == ST_TURN) begin
      // TURN is only entered with a full slot; the write is committed.
      issue_wr = full;
    end else if (want_wr) begin
      if (state == ST_READ) to_turn = 1'b1;
      else                  issue_wr = 1'b1;
    end else if (bus.rd_req) begin
      grant_rd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= mem_en_q && !mem_we_q;
      mem_en_q   <= issue_wr || grant_rd;
      mem_we_q   <= issue_wr;
      if (issue_wr) begin
        mem_addr_q  <= slot_addr;
        mem_wdata_q <= slot_data;
      end else if (grant_rd) begin
        mem_addr_q <= bus.rd_addr;
      end

      if (issue_wr)      state <= ST_WRITE;
      else if (to_turn)  state <= ST_TURN;
      else if (grant_rd) state <= ST_READ;
      else               state <= ST_IDLE;
    end
  end

  assign bus.rd_gnt    = grant_rd;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.wr_done   = issue_wr;
  assign bus.forced    = issue_wr && starve && active && bus.rd_req;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a read-only frame RAM model.
// RAM content at address a is a[7:0]*5 + 0x11.
module tb_frame_mem_arbiter;

  logic clk;
  logic clr_n;
  int   n_tests;
  int   n_fail;

  frame_mem_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus ();

  frame_mem_arbiter #(.ADDR_W(17), .DATA_W(8), .STARVE_MAX(16)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= bus.mem_addr[7:0] * 8'd5 + 8'h11;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_rd [4];
  int         cnt;
  bit         done;
  bit         seen_valid;
  bit         seen_wr;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_rd  = '{8'h11, 8'h16, 8'h1B, 8'h20};
    clr_n   = 1'b0;
    bus.hblank = 1'b0; bus.vblank = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mem_rdata = '0;

    // reset state
    sample();
    chk("rst_mem_en",   32'(bus.mem_en),   32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    clr_n = 1'b1;
    tick();

    // 1: back-to-back reads, 2-cycle latency
    for (int k = 0; k < 6; k++) begin
      bus.rd_req  = (k < 4);
      bus.rd_addr = 17'(k);
      sample();
      chk("t1_gnt", 32'(bus.rd_gnt), (k < 4) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("t1_valid", 32'(bus.rd_valid), 32'd1);
        chk("t1_data",  32'(bus.rd_data),  32'(exp_rd[k-2]));
      end else begin
        chk("t1_novalid", 32'(bus.rd_valid), 32'd0);
      end
      tick();
    end
    sample();
    chk("t1_valid_end", 32'(bus.rd_valid), 32'd0);
    tick();

    // 2: vblank with full slot after READ -> TURN then write, then read
    bus.rd_req = 1'b1; bus.rd_addr = 17'h10;
    bus.wr_req = 1'b1; bus.wr_addr = 17'h100; bus.wr_data = 8'hA5;
    sample();
    chk("t2_gnt_a",   32'(bus.rd_gnt),   32'd1);
    chk("t2_wrrdy_a", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_req = 1'b0; bus.vblank = 1'b1;
    sample();
    chk("t2_turn_gnt",  32'(bus.rd_gnt),   32'd0);
    chk("t2_turn_done", 32'(bus.wr_done),  32'd0);
    chk("t2_full",      32'(bus.wr_ready), 32'd0);
    tick();
    sample();
    chk("t2_turn_memen", 32'(bus.mem_en),  32'd0);
    chk("t2_done",       32'(bus.wr_done), 32'd1);
    chk("t2_forced",     32'(bus.forced),  32'd0);
    chk("t2_gnt_c",      32'(bus.rd_gnt),  32'd0);
    tick();
    sample();
    chk("t2_mem_we",    32'(bus.mem_we),    32'd1);
    chk("t2_mem_addr",  32'(bus.mem_addr),  32'h100);
    chk("t2_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
    chk("t2_gnt_d",     32'(bus.rd_gnt),    32'd1);
    chk("t2_wrrdy_d",   32'(bus.wr_ready),  32'd1);
    tick();
    bus.rd_req = 1'b0; bus.vblank = 1'b0;
    tick();
    tick();

    // 3: starvation in active video with rd_req held
    bus.rd_req = 1'b1; bus.rd_addr = 17'h20;
    bus.wr_req = 1'b1; bus.wr_addr = 17'h123; bus.wr_data = 8'h3C;
    sample();
    chk("t3_gnt_w",   32'(bus.rd_gnt),   32'd1);
    chk("t3_wrrdy_w", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_req = 1'b0;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      sample();
      if (bus.rd_gnt && !bus.wr_done) cnt++;
      else done = 1'b1;
      if (!done) tick();
    end
    chk("t3_wait_cycles", 32'(cnt), 32'd16);
    chk("t3_turn_done",   32'(bus.wr_done), 32'd0);
    tick();
    sample();
    chk("t3_done",   32'(bus.wr_done), 32'd1);
    chk("t3_forced", 32'(bus.forced),  32'd1);
    chk("t3_gnt",    32'(bus.rd_gnt),  32'd0);
    tick();
    sample();
    chk("t3_mem_we",    32'(bus.mem_we),    32'd1);
    chk("t3_mem_addr",  32'(bus.mem_addr),  32'h123);
    chk("t3_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
    chk("t3_forced_clr", 32'(bus.forced),   32'd0);
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();

    // 4: reset between read accept and rd_valid
    bus.rd_req = 1'b1; bus.rd_addr = 17'h5;
    bus.wr_req = 1'b1; bus.wr_addr = 17'h77; bus.wr_data = 8'h99;
    sample();
    chk("t4_gnt", 32'(bus.rd_gnt), 32'd1);
    tick();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    clr_n = 1'b0;
    sample();
    chk("t4_rst_memen", 32'(bus.mem_en),   32'd0);
    chk("t4_rst_wrrdy", 32'(bus.wr_ready), 32'd1);
    tick();
    clr_n = 1'b1;
    seen_valid = 1'b0;
    seen_wr    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      seen_valid = seen_valid | bus.rd_valid;
      seen_wr    = seen_wr | bus.wr_done | bus.mem_en;
      tick();
    end
    chk("t4_no_valid",  32'(seen_valid),   32'd0);
    chk("t4_no_write",  32'(seen_wr),      32'd0);
    chk("t4_wrrdy_end", 32'(bus.wr_ready), 32'd1);

    // 5: streaming writes with no reads
    for (int k = 0; k < 8; k++) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = 17'(32'h200 + k / 2);
      bus.wr_data = 8'(32'h50 + k / 2);
      sample();
      chk("t5_wrrdy", 32'(bus.wr_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t5_done",  32'(bus.wr_done),  (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 2 && (k % 2 == 0)) begin
        chk("t5_mem_we",    32'(bus.mem_we),    32'd1);
        chk("t5_mem_addr",  32'(bus.mem_addr),  32'h200 + 32'((k - 2) / 2));
        chk("t5_mem_wdata", 32'(bus.mem_wdata), 32'h50 + 32'((k - 2) / 2));
      end
      tick();
    end
    bus.wr_req = 1'b0;
    tick();
    tick();

    // 6a: hblank rises as slot is full after a READ -> TURN first
    bus.rd_req = 1'b1; bus.rd_addr = 17'h30;
    bus.wr_req = 1'b1; bus.wr_addr = 17'h1AB; bus.wr_data = 8'h5A;
    sample();
    chk("t6a_gnt_x", 32'(bus.rd_gnt), 32'd1);
    tick();
    bus.wr_req = 1'b0; bus.hblank = 1'b1;
    sample();
    chk("t6a_turn_gnt",  32'(bus.rd_gnt),  32'd0);
    chk("t6a_turn_done", 32'(bus.wr_done), 32'd0);
    tick();
    sample();
    chk("t6a_done",   32'(bus.wr_done), 32'd1);
    chk("t6a_forced", 32'(bus.forced),  32'd0);
    tick();
    sample();
    chk("t6a_mem_addr", 32'(bus.mem_addr), 32'h1AB);
    chk("t6a_gnt",      32'(bus.rd_gnt),   32'd1);
    tick();
    bus.hblank = 1'b0; bus.rd_req = 1'b0;
    tick();
    tick();

    // 6b: slot full, last op not READ, hblank rises with rd_req -> write same cycle
    bus.wr_req = 1'b1; bus.wr_addr = 17'h1CD; bus.wr_data = 8'hC3;
    sample();
    chk("t6b_wrrdy", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_req = 1'b0; bus.hblank = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 17'h31;
    sample();
    chk("t6b_done", 32'(bus.wr_done), 32'd1);
    chk("t6b_gnt",  32'(bus.rd_gnt),  32'd0);
    tick();
    sample();
    chk("t6b_mem_we",    32'(bus.mem_we),    32'd1);
    chk("t6b_mem_wdata", 32'(bus.mem_wdata), 32'hC3);
    chk("t6b_gnt_next",  32'(bus.rd_gnt),    32'd1);
    tick();
    bus.hblank = 1'b0; bus.rd_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
